// File: rtl/mii_tx_fcs_framer.sv
// MII transmit framer: preamble/SFD, payload, optional pad, FCS, IFG.
// Define MII_TX_PAD_EN to pad short frames to MIN_FRAME_NIBBLES.
module mii_tx_fcs_framer #(
    parameter int PREAMBLE_NIBBLES  = 15,
`ifdef MII_TX_PAD_EN
    parameter int MIN_FRAME_NIBBLES = 120,
`endif
    parameter int IFG_NIBBLES       = 24
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       mii_tx_en,
    output logic [3:0] mii_txd,
    output logic       mii_tx_er,
    output logic       underrun,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_SFD, S_DATA,
        S_PAD, S_FCS, S_IFG, S_DISCARD
    } state_t;

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_NIBBLES - 1);
    localparam logic [7:0] IFG_LAST = 8'(IFG_NIBBLES - 1);
    localparam logic [7:0] FCS_LAST = 8'd7;

`ifdef MII_TX_PAD_EN
    localparam int CW = $clog2(MIN_FRAME_NIBBLES + 1);
    localparam logic [CW-1:0] MIN_CNT  = CW'(MIN_FRAME_NIBBLES);
    localparam logic [CW-1:0] MIN_LAST = CW'(MIN_FRAME_NIBBLES - 1);
    logic [CW-1:0] count_q, count_d;
`endif

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [31:0] fcs_inv;
    logic        tx_en_q, tx_en_d;
    logic [3:0]  txd_q, txd_d;
    logic        tx_er_q, tx_er_d;
    logic        underrun_q, underrun_d;

    function automatic logic [31:0] crc32_4bit(
        input logic [31:0] c,
        input logic [3:0]  d
    );
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 4; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    assign fcs_inv   = ~crc_q;
    assign in_ready  = (state_q == S_DATA) || (state_q == S_DISCARD);
    assign busy      = (state_q != S_IDLE);
    assign mii_tx_en = tx_en_q;
    assign mii_txd   = txd_q;
    assign mii_tx_er = tx_er_q;
    assign underrun  = underrun_q;

    // Next state, CRC/counters and the next value of every MII pin.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        tx_en_d    = 1'b0;
        txd_d      = 4'h0;
        tx_er_d    = 1'b0;
        underrun_d = 1'b0;
`ifdef MII_TX_PAD_EN
        count_d    = count_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_PREAMBLE;
                    cnt_d   = '0;
                end
            end
            S_PREAMBLE: begin
                tx_en_d = 1'b1;
                txd_d   = 4'h5;
                crc_d   = '1;
`ifdef MII_TX_PAD_EN
                count_d = '0;
`endif
                if (cnt_q == PRE_LAST) begin
                    state_d = S_SFD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_SFD: begin
                tx_en_d = 1'b1;
                txd_d   = 4'hD;
                state_d = S_DATA;
            end
            S_DATA: begin
                tx_en_d = 1'b1;
                if (in_valid) begin
                    txd_d = in_data;
                    crc_d = crc32_4bit(crc_q, in_data);
`ifdef MII_TX_PAD_EN
                    if (count_q != MIN_CNT) count_d = count_q + 1'b1;
                    if (in_last) begin
                        cnt_d = '0;
                        if (int'(count_q) + 1 < MIN_FRAME_NIBBLES)
                            state_d = S_PAD;
                        else
                            state_d = S_FCS;
                    end
`else
                    if (in_last) begin
                        cnt_d   = '0;
                        state_d = S_FCS;
                    end
`endif
                end else begin
                    tx_er_d    = 1'b1;
                    underrun_d = 1'b1;
                    state_d    = S_DISCARD;
                end
            end
`ifdef MII_TX_PAD_EN
            S_PAD: begin
                tx_en_d = 1'b1;
                crc_d   = crc32_4bit(crc_q, 4'h0);
                count_d = count_q + 1'b1;
                if (count_q == MIN_LAST) begin
                    state_d = S_FCS;
                    cnt_d   = '0;
                end
            end
`endif
            S_FCS: begin
                tx_en_d = 1'b1;
                txd_d   = fcs_inv[{cnt_q[2:0], 2'b00} +: 4];
                if (cnt_q == FCS_LAST) begin
                    state_d = S_IFG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_IFG: begin
                if (cnt_q == IFG_LAST) begin
                    cnt_d   = '0;
                    // Chain straight into a waiting frame so the gap is exact.
                    state_d = in_valid ? S_PREAMBLE : S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DISCARD: begin
                if (in_valid && in_last) begin
                    state_d = S_IFG;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, CRC and registered MII outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            crc_q      <= '1;
            tx_en_q    <= 1'b0;
            txd_q      <= 4'h0;
            tx_er_q    <= 1'b0;
            underrun_q <= 1'b0;
`ifdef MII_TX_PAD_EN
            count_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            crc_q      <= crc_d;
            tx_en_q    <= tx_en_d;
            txd_q      <= txd_d;
            tx_er_q    <= tx_er_d;
            underrun_q <= underrun_d;
`ifdef MII_TX_PAD_EN
            count_q    <= count_d;
`endif
        end
    end

endmodule

// File: tb/tb_mii_tx_fcs_framer.sv
// Directed bench for mii_tx_fcs_framer.
// Builds either way; pad expectations follow MII_TX_PAD_EN.
module tb_mii_tx_fcs_framer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       mii_tx_en;
    logic [3:0] mii_txd;
    logic       mii_tx_er;
    logic       underrun;
    logic       busy;

    int checks = 0;
    int failures = 0;

`ifdef MII_TX_PAD_EN
    localparam int MINF = 120;
`else
    localparam int MINF = 0;
`endif
    localparam int PAD6 = (MINF > 28) ? MINF - 28 : 0;

    typedef logic [3:0] nq_t[$];

    typedef struct packed {
        logic       en;
        logic [3:0] d;
        logic       er;
        logic       ur;
        logic       rdy;
        logic       bsy;
    } smp_t;

    smp_t tr[$];
    bit   rec = 1'b0;

    always #20 clk = ~clk;

    mii_tx_fcs_framer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .mii_tx_en (mii_tx_en),
        .mii_txd   (mii_txd),
        .mii_tx_er (mii_tx_er),
        .underrun  (underrun),
        .busy      (busy)
    );

    always @(negedge clk)
        if (rec)
            tr.push_back('{en: mii_tx_en, d: mii_txd, er: mii_tx_er,
                           ur: underrun, rdy: in_ready, bsy: busy});

    initial begin
        #4_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_model(input nq_t n);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (n[i])
            for (int b = 0; b < 4; b++) begin
                fb = c[0] ^ n[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        return c;
    endfunction

    function automatic nq_t build(input nq_t p);
        nq_t         body;
        nq_t         e;
        logic [31:0] f;
        body = p;
        while (body.size() < MINF) body.push_back(4'h0);
        f = ~crc_model(body);
        e = {};
        repeat (15) e.push_back(4'h5);
        e.push_back(4'hD);
        foreach (body[i]) e.push_back(body[i]);
        for (int k = 0; k < 8; k++) e.push_back(f[4*k +: 4]);
        return e;
    endfunction

    task automatic find_run(input int from, output int s, output int len);
        s = -1;
        len = 0;
        for (int i = from; i < tr.size(); i++) begin
            if (tr[i].en) begin
                if (s < 0) s = i;
                len++;
            end else if (s >= 0) begin
                break;
            end
        end
    endtask

    task automatic check_frame(input string tag, input int s,
                               input int len, input nq_t e);
        int errs = 0;
        int ers = 0;
        chk({tag, "_len"}, len, e.size());
        for (int i = 0; i < len && i < e.size(); i++) begin
            if (tr[s+i].d !== e[i]) errs++;
            if (tr[s+i].er) ers++;
        end
        chk({tag, "_data_errs"}, errs, 0);
        chk({tag, "_tx_er"}, ers, 0);
    endtask

    function automatic logic [31:0] fcs_word(input int s, input int len);
        logic [31:0] w = '0;
        if (s >= 0 && len >= 8)
            for (int k = 0; k < 8; k++) w[4*k +: 4] = tr[s+len-8+k].d;
        return w;
    endfunction

    task automatic send(input nq_t p, input int drop_at, input bit keep);
        int i = 0;
        int budget = 3000;
        bit dropped = 1'b0;
        bit acc;
        while (i < p.size() && budget > 0) begin
            @(negedge clk);
            budget--;
            if (i == drop_at && !dropped) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                @(posedge clk);
                dropped = 1'b1;
            end else begin
                in_valid = 1'b1;
                in_data  = p[i];
                in_last  = (i == p.size() - 1);
                acc = in_ready;
                @(posedge clk);
                if (acc) i++;
            end
        end
        chk("send_done", i, p.size());
        if (!keep) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    initial begin
        nq_t  p1, p28, p130, p20, pa, p1n, e;
        int   s, len, s2, len2, cnt, cnt2;
        logic [7:0] b;

        for (int k = 0; k < 9; k++) begin
            b = 8'h31 + 8'(k);
            p1.push_back(b[3:0]);
            p1.push_back(b[7:4]);
        end
        for (int k = 0; k < 28; k++) p28.push_back(4'(k*5 + 3));
        for (int k = 0; k < 130; k++) p130.push_back(4'(k*7 + 1));
        for (int k = 0; k < 20; k++) p20.push_back(4'(k + 2));
        for (int k = 0; k < 24; k++) pa.push_back(4'(k ^ 5));
        p1n.push_back(4'hA);

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_tx_en", mii_tx_en, 1'b0);
        chk("rst_txd", mii_txd, 4'h0);
        chk("rst_tx_er", mii_tx_er, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_underrun", underrun, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_tx_en", mii_tx_en, 1'b0);

        // 1: "123456789"
        tr.delete();
        rec = 1'b1;
        send(p1, -1, 1'b0);
        repeat (MINF + 60) @(negedge clk);
        rec = 1'b0;
        find_run(0, s, len);
        check_frame("t1", s, len, build(p1));
`ifndef MII_TX_PAD_EN
        chk("t1_en_cycles", len, 42);
        chk("t1_fcs", fcs_word(s, len), 32'hCBF43926);
`endif
        cnt = 0;
        for (int i = 0; i < 24; i++)
            if (s >= 0 && (s+len+i >= tr.size() || tr[s+len+i].en)) cnt++;
        chk("t1_ifg_idle", cnt, 0);
        chk("t1_busy_end", tr[tr.size()-1].bsy, 1'b0);

        // 2: 14-byte frame
        tr.delete();
        rec = 1'b1;
        send(p28, -1, 1'b0);
        repeat (MINF + 60) @(negedge clk);
        rec = 1'b0;
        find_run(0, s, len);
        check_frame("t2", s, len, build(p28));
`ifdef MII_TX_PAD_EN
        chk("t2_total", len, 144);
`else
        chk("t2_total", len, 52);
`endif

        // 3: 130-nibble frame, no pad either way
        tr.delete();
        rec = 1'b1;
        send(p130, -1, 1'b0);
        repeat (60) @(negedge clk);
        rec = 1'b0;
        find_run(0, s, len);
        chk("t3_total", len, 154);
        check_frame("t3", s, len, build(p130));

        // 4: underrun after 10 nibbles, then a good frame
        tr.delete();
        rec = 1'b1;
        send(p20, 10, 1'b1);
        send(p1, -1, 1'b0);
        repeat (MINF + 60) @(negedge clk);
        rec = 1'b0;
        find_run(0, s, len);
        chk("t4_abort_len", len, 27);
        cnt = 0;
        for (int i = 0; i < 26 && s >= 0 && s+i < tr.size(); i++) begin
            if (i < 15 && tr[s+i].d !== 4'h5) cnt++;
            if (i == 15 && tr[s+i].d !== 4'hD) cnt++;
            if (i > 15 && tr[s+i].d !== p20[i-16]) cnt++;
        end
        chk("t4_abort_data_errs", cnt, 0);
        if (s >= 0 && s+26 < tr.size()) begin
            chk("t4_er_last", tr[s+26].er, 1'b1);
            chk("t4_ur_last", tr[s+26].ur, 1'b1);
            chk("t4_txd_abort", tr[s+26].d, 4'h0);
        end else begin
            chk("t4_abort_seen", 0, 1);
        end
        cnt = 0;
        cnt2 = 0;
        foreach (tr[i]) begin
            if (tr[i].er) cnt++;
            if (tr[i].ur) cnt2++;
        end
        chk("t4_er_pulses", cnt, 1);
        chk("t4_ur_pulses", cnt2, 1);
        find_run(s + len, s2, len2);
        chk("t4_gap", s2 - (s + len), 34);
        check_frame("t4_next", s2, len2, build(p1));

        // 5: back-to-back frames, in_valid held
        tr.delete();
        rec = 1'b1;
        send(pa, -1, 1'b1);
        send(p1, -1, 1'b0);
        repeat (MINF + 60) @(negedge clk);
        rec = 1'b0;
        find_run(0, s, len);
        check_frame("t5_a", s, len, build(pa));
        find_run(s + len, s2, len2);
        chk("t5_gap", s2 - (s + len), 24);
        check_frame("t5_b", s2, len2, build(p1));
        cnt = 0;
        foreach (tr[i]) if (tr[i].rdy) cnt++;
        chk("t5_ready_cycles", cnt, pa.size() + p1.size());

        // 6: reset during FCS nibble 3
        e = build(p28);
        send(p28, -1, 1'b0);
        repeat (4 + PAD6) @(negedge clk);
        chk("t6_pre_en", mii_tx_en, 1'b1);
        chk("t6_pre_fcs3", mii_txd, e[e.size()-5]);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_en", mii_tx_en, 1'b0);
        chk("t6_rst_txd", mii_txd, 4'h0);
        chk("t6_rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        tr.delete();
        rec = 1'b1;
        repeat (20) @(negedge clk);
        cnt = 0;
        foreach (tr[i]) if (tr[i].en || tr[i].bsy) cnt++;
        chk("t6_quiet_after", cnt, 0);
        send(p1, -1, 1'b0);
        repeat (MINF + 60) @(negedge clk);
        rec = 1'b0;
        find_run(0, s, len);
        check_frame("t6_next", s, len, build(p1));
`ifndef MII_TX_PAD_EN
        chk("t6_fcs", fcs_word(s, len), 32'hCBF43926);
`endif

        // 7: single-nibble payload
        tr.delete();
        rec = 1'b1;
        send(p1n, -1, 1'b0);
        repeat (MINF + 60) @(negedge clk);
        rec = 1'b0;
        find_run(0, s, len);
`ifdef MII_TX_PAD_EN
        chk("t7_total", len, 144);
`else
        chk("t7_total", len, 25);
`endif
        check_frame("t7", s, len, build(p1n));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
